// File: rtl/csa_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-select add/subtract sequencer.
package csa_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;

    // Slice counter width; a single-slice datapath still needs one bit.
    function automatic int cnt_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/csa_serial_add_ctrl_if.sv
// Request/result handshake bundle between a requester (master) and the sequencer (slave).
interface csa_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Both channels transfer on a clock edge where valid and ready are both 1;
    // valid must stay asserted and its payload stable until that edge.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-select adder slice: two ripple chains, chosen by the incoming carry.
module csa_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c0;
    logic [4:0] c1;
    logic [3:0] s0;
    logic [3:0] s1;

    always_comb begin
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0[i]   = x[i] ^ y[i] ^ c0[i];
            c0[i+1] = (x[i] & y[i]) | (c0[i] & (x[i] ^ y[i]));
            s1[i]   = x[i] ^ y[i] ^ c1[i];
            c1[i+1] = (x[i] & y[i]) | (c1[i] & (x[i] ^ y[i]));
        end
    end

    assign s  = ci ? s1 : s0;
    assign co = ci ? c1[4] : c0[4];

endmodule

// File: rtl/csa_serial_add_ctrl.sv
// Nibble-serial add/subtract: one csa_slice4 reused LSB first, carry held in a register between slices.
module csa_serial_add_ctrl
    import csa_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_serial_add_ctrl_if.slave  bus,
    output state_e                state_o
);

    // WIDTH must be a positive multiple of SLICE_W.
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = cnt_w(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_x;
    logic [3:0]       slice_y;
    logic [3:0]       slice_s;
    logic             slice_co;

    assign slice_x = a_q[k_q*SLICE_W +: SLICE_W];
    assign slice_y = b_q[k_q*SLICE_W +: SLICE_W];

    csa_slice4 u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // Subtract is a + ~b + 1, so the carry register doubles as the +1.
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_co;
                if (k_q == K_LAST) begin
                    cout_d  = slice_co;
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[3] ^ slice_co;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Directed bench for csa_serial_add_ctrl (WIDTH=16) with an expected-result queue.
module tb_csa_serial_add_ctrl;
    import csa_serial_add_ctrl_pkg::*;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic   clk;
    logic   rst;
    state_e dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q[$];

    csa_serial_add_ctrl_if #(.WIDTH(W)) bus_if ();

    csa_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, cout, sum}; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        int n;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("send_in_ready", 32'(bus_if.in_ready), 32'd1);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = cin;
        bus_if.sub      = sub;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        exp_q.push_back(model(a, b, cin, sub));
    endtask

    // Waits for the result, optionally stalls it, then pops and compares.
    task automatic collect(input string tag, input int hold);
        int           n;
        int           runs;
        logic [W+1:0] e;
        n    = 0;
        runs = 0;
        bus_if.out_ready = (hold == 0);
        while (bus_if.out_valid !== 1'b1 && n < 40) begin
            if (dbg_state == RUN) runs++;
            tick();
            n++;
        end
        check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_run_cycles"}, 32'(runs), 32'(NSLICE));
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
            check({tag, "_hold_sum"}, 32'(bus_if.sum), 32'(e[W-1:0]));
            check({tag, "_hold_cout"}, 32'(bus_if.cout), 32'(e[W]));
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.a        = W'($urandom_range(0, 65535));
            bus_if.b        = W'($urandom_range(0, 65535));
            tick();
        end
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        check({tag, "_sum"}, 32'(bus_if.sum), 32'(e[W-1:0]));
        check({tag, "_cout"}, 32'(bus_if.cout), 32'(e[W]));
        check({tag, "_overflow"}, 32'(bus_if.overflow), 32'(e[W+1]));
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_post_idle"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_post_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b0;
        rst = 1'b1;
        #3;
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_sum", 32'(bus_if.sum), 32'd0);
        check("rst_cout", 32'(bus_if.cout), 32'd0);
        check("rst_overflow", 32'(bus_if.overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        tick();
        rst = 1'b0;
        tick();

        send(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        collect("add_basic", 0);
        check("add_basic_const", 32'(bus_if.sum), 32'h2233);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        collect("carry_full", 0);
        check("carry_full_cout_const", 32'(bus_if.cout), 32'd1);

        send(16'h0FFF, 16'h0000, 1'b1, 1'b0);
        collect("carry_cin", 0);
        check("carry_cin_const", 32'(bus_if.sum), 32'h1000);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        collect("ovf_add", 0);
        check("ovf_add_const", 32'(bus_if.overflow), 32'd1);

        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        collect("ovf_sub", 0);
        check("ovf_sub_const", 32'(bus_if.sum), 32'h7FFF);

        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        collect("sub_borrow", 0);
        check("sub_borrow_const", 32'(bus_if.sum), 32'hFFFE);

        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        collect("sub_noborrow", 0);
        check("sub_noborrow_cout_const", 32'(bus_if.cout), 32'd1);

        send(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        collect("backpressure", 3);

        // Abort at k=2 while a carry is in flight.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        tick();
        check("abort_state_run", 32'(dbg_state), 32'(RUN));
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("abort_sum", 32'(bus_if.sum), 32'd0);
        check("abort_cout", 32'(bus_if.cout), 32'd0);
        check("abort_overflow", 32'(bus_if.overflow), 32'd0);
        check("abort_in_ready", 32'(bus_if.in_ready), 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        tick();
        rst = 1'b0;
        tick();
        check("abort_idle", 32'(dbg_state), 32'(IDLE));

        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        collect("after_abort", 0);
        check("after_abort_const", 32'(bus_if.sum), 32'h0002);

        for (int i = 0; i < 6; i++) begin
            send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            collect("random", i % 3);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
